// File: rtl/tt_sweep_ctrl_if.sv
// Stimulus/capture bundle between the truth-table sweep controller and its environment.
// master = controller side (drives vector and results), slave = bench/lab side.
interface tt_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic                 abort;
  logic [N_IN-1:0]      abc_out;
  logic                 y_a;
  logic                 y_b;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_a;
  logic [2**N_IN-1:0]   table_b;
  logic                 mismatch;
  logic [N_IN-1:0]      mismatch_idx;

  modport master (
    input  start, abort, y_a, y_b,
    output abc_out, busy, done, table_a, table_b, mismatch, mismatch_idx
  );

  modport slave (
    output start, abort, y_a, y_b,
    input  abc_out, busy, done, table_a, table_b, mismatch, mismatch_idx
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector into two implementations, captures both truth tables, flags the first mismatch.
// Done pulses 2**N_IN*(SETTLE_CYC+1) clocks after start; TT_STOP_ON_MISMATCH_EN ends the sweep at the first mismatch.
module tt_sweep_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  tt_sweep_ctrl_if.master bus
);
  localparam int TW = 2**N_IN;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] abc_q, abc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   tab_a_q, tab_a_d;
  logic [TW-1:0]   tab_b_q, tab_b_d;
  logic            mm_q, mm_d;
  logic [N_IN-1:0] mm_idx_q, mm_idx_d;
  logic            stop_early;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tab_a_d    = tab_a_q;
    tab_b_d    = tab_b_q;
    mm_d       = mm_q;
    mm_idx_d   = mm_idx_q;
    stop_early = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_DRIVE;
          idx_d    = '0;
          cnt_d    = '0;
          tab_a_d  = '0;
          tab_b_d  = '0;
          mm_d     = 1'b0;
          mm_idx_d = '0;
        end
      end
      S_DRIVE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // abort discards the pending capture entirely
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          tab_a_d[idx_q] = bus.y_a;
          tab_b_d[idx_q] = bus.y_b;
          if ((bus.y_a != bus.y_b) && !mm_q) begin
            mm_d     = 1'b1;
            mm_idx_d = idx_q;
`ifdef TT_STOP_ON_MISMATCH_EN
            stop_early = 1'b1;
`else
            stop_early = 1'b0;
`endif
          end
          if ((idx_q == IDX_LAST) || stop_early) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = S_DRIVE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next-state view so they align with the state
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    abc_d  = busy_d ? idx_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      abc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tab_a_q  <= '0;
      tab_b_q  <= '0;
      mm_q     <= 1'b0;
      mm_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      abc_q    <= abc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tab_a_q  <= tab_a_d;
      tab_b_q  <= tab_b_d;
      mm_q     <= mm_d;
      mm_idx_q <= mm_idx_d;
    end
  end

  assign bus.abc_out      = abc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_a      = tab_a_q;
  assign bus.table_b      = tab_b_q;
  assign bus.mismatch     = mm_q;
  assign bus.mismatch_idx = mm_idx_q;
endmodule
